// File: rtl/corr_readout_if.sv
// Byte stream from corr_readout toward the host-link transmitter.
// A byte moves on a clk edge where tx_valid && tx_ready; while tx_valid && !tx_ready, tx_data and tx_valid hold steady, and tx_valid never falls without a transfer.
interface corr_readout_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/corr_readout.sv
// Drains the correlator accumulator bank into a framed byte stream (header, words MSB first, XOR checksum),
// then optionally issues the bank clear, arbitrated against the sample strobe.
module corr_readout #(
  parameter int          NWORD  = 64,
  parameter int          AW     = 6,
  parameter int          DW     = 32,
  parameter int          RD_LAT = 3,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clear_en,
  input  logic          sin,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          clr,
  output logic          busy,
  output logic          done,
  corr_readout_if.master tx,
  output logic [2:0]    dbg_state_o
);

  localparam int              NB         = DW / 8;
  localparam int              BCW        = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BCW-1:0]  LAST_BYTE  = BCW'(NB - 1);
  localparam logic [AW-1:0]   LAST_ADDR  = AW'(NWORD - 1);
  localparam logic [6:0]      FETCH_LAST = 7'(RD_LAT - 1);
  localparam logic [6:0]      CLRW_LAST  = 7'd64;
  localparam logic [6:0]      BANK_BUSY  = 7'd64;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FETCH, S_SEND, S_CSUM, S_CLR, S_CLRW, S_DONE
  } state_t;

  state_t          state_q;
  logic            clr_en_q;
  logic            rd_en_q;
  logic [AW-1:0]   rd_addr_q;
  logic            clr_q;
  logic            busy_q;
  logic            done_q;
  logic            tx_valid_q;
  logic [7:0]      tx_data_q;
  logic [7:0]      csum_q;
  logic [DW-1:0]   shreg_q;
  logic [DW-1:0]   shreg_d;
  logic [BCW-1:0]  byte_q;
  logic [6:0]      cnt_q;
  logic [6:0]      shadow_q;

  assign shreg_d = shreg_q << 8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      clr_en_q   <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      csum_q     <= '0;
      shreg_q    <= '0;
      byte_q     <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_HDR;
            clr_en_q   <= clear_en;
            busy_q     <= 1'b1;
            rd_en_q    <= 1'b1;
            rd_addr_q  <= '0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= HDR;
            csum_q     <= '0;
          end
        end
        S_HDR: begin
          if (tx.tx_ready) begin
            state_q    <= S_FETCH;
            tx_valid_q <= 1'b0;
            cnt_q      <= '0;
          end
        end
        // Always waits the full read latency from its own entry, even for word 0.
        S_FETCH: begin
          if (cnt_q == FETCH_LAST) begin
            state_q    <= S_SEND;
            shreg_q    <= rd_data;
            tx_data_q  <= rd_data[DW-1 -: 8];
            tx_valid_q <= 1'b1;
            byte_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end
        S_SEND: begin
          if (tx.tx_ready) begin
            csum_q    <= csum_q ^ tx_data_q;
            shreg_q   <= shreg_d;
            tx_data_q <= shreg_d[DW-1 -: 8];
            byte_q    <= byte_q + BCW'(1);
            if (byte_q == LAST_BYTE) begin
              if (rd_addr_q == LAST_ADDR) begin
                state_q   <= S_CSUM;
                tx_data_q <= csum_q ^ tx_data_q;
              end else begin
                state_q    <= S_FETCH;
                tx_valid_q <= 1'b0;
                rd_addr_q  <= rd_addr_q + AW'(1);
                cnt_q      <= '0;
              end
            end
          end
        end
        S_CSUM: begin
          if (tx.tx_ready) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            rd_en_q    <= 1'b0;
            if (clr_en_q) begin
              state_q  <= S_CLR;
              shadow_q <= 7'd1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        // Shadow counter mirrors the bank's busy time; the clear only counts when clr is seen on an idle, sin-free cycle.
        S_CLR: begin
          if (shadow_q != 7'd0) begin
            shadow_q <= shadow_q - 7'd1;
            clr_q    <= 1'b1;
          end else if (sin) begin
            shadow_q <= BANK_BUSY;
            clr_q    <= 1'b1;
          end else if (clr_q) begin
            state_q <= S_CLRW;
            clr_q   <= 1'b0;
            cnt_q   <= '0;
          end else begin
            clr_q <= 1'b1;
          end
        end
        S_CLRW: begin
          if (cnt_q == CLRW_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign clr         = clr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_data  = tx_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_corr_readout.sv
// Bench for corr_readout: a bank model with read latency and clear/busy behaviour, a byte sink with random
// back-pressure, and a frame reference built from the bank image with plain arithmetic.
module tb_corr_readout;

  localparam int NWORD = 64;
  localparam int AW    = 6;
  localparam int DW    = 32;

  logic          clk;
  logic          rst_n;
  logic          start_main;
  logic          start_inj;
  logic          clear_en;
  logic          sin;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          clr;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  corr_readout_if tx_if();

  corr_readout dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_main | start_inj),
    .clear_en   (clear_en),
    .sin        (sin),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .clr        (clr),
    .busy       (busy),
    .done       (done),
    .tx         (tx_if),
    .dbg_state_o(dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bank model: two register stages give capture RD_LAT=3 edges after the address is driven
  logic [DW-1:0] mem[NWORD];
  logic [DW-1:0] img[NWORD];
  logic [DW-1:0] exp_bank[NWORD];
  logic [DW-1:0] pipe0 = '0;
  logic [DW-1:0] pipe1 = '0;
  logic          rd_en_d = 1'b0;
  logic          load_req;
  int            bank_busy = 0;
  int            bank_clears = 0;

  always @(posedge clk) begin
    pipe0   <= mem[rd_addr];
    pipe1   <= pipe0;
    rd_en_d <= rd_en;
    if (load_req) begin
      for (int i = 0; i < NWORD; i++) mem[i] <= img[i];
    end else if (clr && !rd_en && !rd_en_d && bank_busy == 0 && !sin) begin
      for (int i = 0; i < NWORD; i++) mem[i] <= '0;
      bank_clears <= bank_clears + 1;
      bank_busy   <= 64;
    end else if (sin && !rd_en && !rd_en_d && bank_busy == 0) begin
      bank_busy <= 64;
    end else if (bank_busy > 0) begin
      bank_busy <= bank_busy - 1;
    end
  end
  assign rd_data = pipe1;

  // scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int stall_err, overlap, done_cnt, clr_cnt;
  int first_hs, last_hs, rd_fall, clr_rise, clr_last, done_cyc, clears_before;

  typedef struct {
    int img_kind;       // 0 keep bank, 1 counting pattern, 2 random
    bit ce;
    int rdy_pct;
    bit sin_pulse;
    int exp_len;
    int exp_clr_cycles;
  } vec_t;

  vec_t vecs[9];

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  function automatic int out_pack();
    return int'({rd_en, rd_addr, clr, tx_if.tx_valid, tx_if.tx_data, busy, done});
  endfunction

  // reference frame: header, each word MSB first, XOR of payload bytes
  task automatic build_expected();
    logic [7:0] x;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    x = '0;
    for (int w = 0; w < NWORD; w++) begin
      for (int k = 3; k >= 0; k--) begin
        b = 8'(exp_bank[w] >> (8 * k));
        exp_q.push_back(b);
        x = x ^ b;
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic prepare_bank(input int kind);
    if (kind != 0) begin
      for (int i = 0; i < NWORD; i++)
        img[i] = (kind == 1) ? DW'(32'h01000000 * i + i) : DW'($urandom);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      exp_bank = img;
    end
  endtask

  // driver + monitor for one frame; mode 0 plain, 1 extra starts at byte 100 and in the done cycle, 2 reset at byte 130
  task automatic run_frame(input bit ce, input int rdy_pct, input bit sin_pulse, input int mode);
    int         budget;
    int         post;
    bit         prev_stall;
    bit         inj100;
    bit         stop;
    logic [7:0] prev_data;
    got_q.delete();
    stall_err = 0; overlap = 0; done_cnt = 0; clr_cnt = 0;
    first_hs = -1; last_hs = -1; rd_fall = -1; clr_rise = -1; clr_last = -1; done_cyc = -1;
    clears_before = bank_clears;
    prev_stall = 1'b0; prev_data = '0; inj100 = 1'b0; stop = 1'b0;
    budget = 0; post = 0;
    start_main = 1'b1;
    clear_en   = ce;
    @(negedge clk);
    start_main = 1'b0;
    clear_en   = 1'b0;
    check("start_to_hdr", int'({busy, rd_en, tx_if.tx_valid, tx_if.tx_data}), 32'h7A5);
    while (post < 20 && budget < 20000 && !stop) begin
      tx_if.tx_ready = ($urandom_range(99) < rdy_pct);
      sin = sin_pulse && clr && (clr_rise < 0);
      start_inj = 1'b0;
      clear_en  = 1'b0;
      if (mode == 1 && ((got_q.size() == 100 && !inj100) || done)) begin
        start_inj = 1'b1;
        clear_en  = 1'b1;
        if (got_q.size() == 100) inj100 = 1'b1;
      end
      if (prev_stall && (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== prev_data)) stall_err++;
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        got_q.push_back(tx_if.tx_data);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (clr && rd_en) overlap++;
      if (clr) begin
        if (clr_rise < 0) clr_rise = cyc;
        clr_last = cyc;
        clr_cnt++;
      end
      if (!rd_en && rd_fall < 0) rd_fall = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0) post++;
      if (mode == 2 && got_q.size() == 130) begin
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", out_pack(), 0);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (clr || tx_if.tx_valid || rd_en) overlap++;
        end
        rst_n = 1'b1;
        stop  = 1'b1;
      end else begin
        @(negedge clk);
        budget++;
      end
    end
    tx_if.tx_ready = 1'b0;
    sin = 1'b0;
    start_inj = 1'b0;
    clear_en = 1'b0;
    check("frame_timeout", int'(budget >= 20000), 0);
  endtask

  task automatic check_frame(input int v, input vec_t t);
    int mism;
    int bad;
    build_expected();
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) mism++;
    check($sformatf("v%0d_len", v), got_q.size(), t.exp_len);
    check($sformatf("v%0d_bytes", v), mism, 0);
    check($sformatf("v%0d_header", v), (got_q.size() > 0) ? int'(got_q[0]) : -1, 32'hA5);
    check($sformatf("v%0d_csum", v), (got_q.size() > 0) ? int'(got_q[got_q.size()-1]) : -1,
          int'(exp_q[exp_q.size()-1]));
    check($sformatf("v%0d_done_count", v), done_cnt, 1);
    check($sformatf("v%0d_stall_stable", v), stall_err, 0);
    check($sformatf("v%0d_clr_rd_overlap", v), overlap, 0);
    check($sformatf("v%0d_idle_after", v), int'({busy, tx_if.tx_valid, rd_en, clr}), 0);
    if (t.rdy_pct == 100) check($sformatf("v%0d_hdr_to_last", v), last_hs - first_hs, 449);
    if (!t.ce) begin
      check($sformatf("v%0d_done_lat", v), done_cyc - last_hs, 1);
      check($sformatf("v%0d_no_clr", v), clr_cnt, 0);
      bad = 0;
      for (int i = 0; i < NWORD; i++) if (mem[i] !== exp_bank[i]) bad++;
      check($sformatf("v%0d_bank_kept", v), bad, 0);
    end else begin
      check($sformatf("v%0d_rd_fall", v), rd_fall - last_hs, 1);
      check($sformatf("v%0d_clr_rise", v), clr_rise - rd_fall, 1);
      check($sformatf("v%0d_clr_cycles", v), clr_cnt, t.exp_clr_cycles);
      check($sformatf("v%0d_done_after_accept", v), done_cyc - clr_last, 66);
      check($sformatf("v%0d_bank_clears", v), bank_clears - clears_before, 1);
      for (int i = 0; i < NWORD; i++) exp_bank[i] = '0;
      bad = 0;
      for (int i = 0; i < NWORD; i++) if (mem[i] !== '0) bad++;
      check($sformatf("v%0d_bank_zero", v), bad, 0);
    end
  endtask

  initial begin
    vec_t plain;
    rst_n = 1'b0;
    start_main = 1'b0;
    start_inj = 1'b0;
    clear_en = 1'b0;
    sin = 1'b0;
    load_req = 1'b0;
    tx_if.tx_ready = 1'b0;

    //          img ce  rdy  sin len  clr
    vecs[0] = '{1, 1'b0, 100, 1'b0, 258, 0};
    vecs[1] = '{1, 1'b0, 30,  1'b0, 258, 0};
    vecs[2] = '{0, 1'b1, 100, 1'b0, 258, 1};
    vecs[3] = '{0, 1'b0, 100, 1'b0, 258, 0};
    vecs[4] = '{1, 1'b1, 100, 1'b1, 258, 66};
    vecs[5] = '{0, 1'b0, 30,  1'b0, 258, 0};
    vecs[6] = '{2, 1'b0, 30,  1'b0, 258, 0};
    vecs[7] = '{2, 1'b1, 50,  1'b1, 258, 66};
    vecs[8] = '{2, 1'b1, 100, 1'b0, 258, 1};
    plain   = '{0, 1'b0, 100, 1'b0, 258, 0};

    repeat (3) @(negedge clk);
    check("reset_outputs", out_pack(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", out_pack(), 0);
    check("post_reset_state", int'(dbg_state), 0);

    for (int v = 0; v < 9; v++) begin
      prepare_bank(vecs[v].img_kind);
      run_frame(vecs[v].ce, vecs[v].rdy_pct, vecs[v].sin_pulse, 0);
      check_frame(v, vecs[v]);
    end

    // extra start pulses mid-frame and in the done cycle must be dropped
    prepare_bank(1);
    run_frame(1'b0, 100, 1'b0, 1);
    check_frame(100, plain);

    // reset at byte 130 of a clear_en frame: no clear, then a clean frame
    prepare_bank(2);
    run_frame(1'b1, 70, 1'b0, 2);
    check("reset_abort_len", got_q.size(), 130);
    check("reset_abort_no_clr", clr_cnt, 0);
    check("reset_abort_quiet", overlap, 0);
    check("reset_abort_bank_clears", bank_clears - clears_before, 0);
    repeat (3) @(negedge clk);
    run_frame(1'b0, 100, 1'b0, 0);
    check_frame(101, plain);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
